// File: rtl/iterative_multi_mode_shifter_if.sv
// Handshake and data bundle for the iterative multi-mode shifter.
// The master drives load/start controls; the slave returns data and status.
interface iterative_multi_mode_shifter_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
);
    logic               Load;
    logic [WIDTH-1:0]   din;
    logic               start;
    logic [2:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic               ser_in;
    logic [WIDTH-1:0]   dout;
    logic               ser_out;
    logic               busy;
    logic               done;

    modport master (
        output Load, din, start, mode, shamt, ser_in,
        input  dout, ser_out, busy, done
    );

    modport slave (
        input  Load, din, start, mode, shamt, ser_in,
        output dout, ser_out, busy, done
    );
endinterface

// File: rtl/iterative_multi_mode_shifter.sv
// Shift/rotate register that moves one bit position per clock
// for a runtime step count, with start/busy/done sequencing.
module iterative_multi_mode_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input logic                          CLK,
    input logic                          RST,
    iterative_multi_mode_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [SHAMT_W-1:0] cnt, cnt_nx;
    logic [2:0]         mode_q, mode_nx;
    logic [WIDTH-1:0]   data, data_nx;
    logic               ser, ser_nx;
    logic [WIDTH-1:0]   step_data;
    logic               step_ser;

    // Single-bit step for the captured mode; reserved modes hold.
    always_comb begin
        step_data = data;
        step_ser  = ser;
        case (mode_q)
            3'b000: begin
                step_data = {data[WIDTH-2:0], bus.ser_in};
                step_ser  = data[WIDTH-1];
            end
            3'b001: begin
                step_data = {bus.ser_in, data[WIDTH-1:1]};
                step_ser  = data[0];
            end
            3'b010: begin
                step_data = {data[WIDTH-1], data[WIDTH-1:1]};
                step_ser  = data[0];
            end
            3'b011: begin
                step_data = {data[WIDTH-2:0], data[WIDTH-1]};
                step_ser  = data[WIDTH-1];
            end
            3'b100: begin
                step_data = {data[0], data[WIDTH-1:1]};
                step_ser  = data[0];
            end
            default: begin
                step_data = data;
                step_ser  = ser;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode_q;
        data_nx  = data;
        ser_nx   = ser;
        if (bus.Load) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            data_nx  = bus.din;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_nx  = bus.mode;
                        cnt_nx   = bus.shamt;
                        state_nx = (bus.shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    data_nx = step_data;
                    ser_nx  = step_ser;
                    cnt_nx  = cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            data   <= '0;
            ser    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mode_q <= mode_nx;
            data   <= data_nx;
            ser    <= ser_nx;
        end
    end

    assign bus.dout    = data;
    assign bus.ser_out = ser;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_iterative_multi_mode_shifter.sv
// Scoreboard bench for the iterative multi-mode shifter.
// Expected results come from an arithmetic model of each operation.
module tb_iterative_multi_mode_shifter;
    localparam int W = 8;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iterative_multi_mode_shifter_if #(.WIDTH(W), .SHAMT_W(S)) bus ();

    iterative_multi_mode_shifter #(.WIDTH(W), .SHAMT_W(S)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           vec = 0;
    int           miss = 0;
    int           done_cnt = 0;
    exp_t         exp_q[$];
    logic [W-1:0] samples[$];
    logic [W-1:0] md = '0;
    logic         ms = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Net effect of n single-bit steps, computed in one go.
    task automatic model_apply(input logic [2:0] m, input int n,
                               input logic b);
        longint unsigned ext, t, fill;
        longint signed   sx, st;
        int              k;
        if (n == 0) return;
        fill = b ? ((64'd1 << n) - 64'd1) : 64'd0;
        case (m)
            3'd0: begin
                ext = (64'(md) << n) | fill;
                md  = ext[W-1:0];
                ms  = ext[W];
            end
            3'd1: begin
                ext = (fill << W) | 64'(md);
                t   = ext >> n;
                md  = t[W-1:0];
                t   = ext >> (n - 1);
                ms  = t[0];
            end
            3'd2: begin
                sx = $signed(md);
                st = sx >>> n;
                md = st[W-1:0];
                st = sx >>> (n - 1);
                ms = st[0];
            end
            3'd3: begin
                k   = n % W;
                ext = 64'({md, md});
                t   = (ext << k) >> W;
                md  = t[W-1:0];
                ms  = md[0];
            end
            3'd4: begin
                k   = n % W;
                ext = 64'({md, md});
                t   = ext >> k;
                md  = t[W-1:0];
                ms  = md[W-1];
            end
            default: ;
        endcase
    endtask

    // Monitor: every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_dout", 32'(bus.dout), 32'(e.d));
                check("done_ser_out", 32'(bus.ser_out), 32'(e.s));
            end
        end
    end

    task automatic do_load(input logic [W-1:0] d);
        bus.Load = 1'b1;
        bus.din  = d;
        @(posedge clk);
        #1;
        bus.Load = 1'b0;
        md = d;
    endtask

    task automatic issue_start(input logic [2:0] m, input logic [S-1:0] n,
                               input logic b, input bit push);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.shamt  = n;
        bus.ser_in = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 3'($urandom);
        bus.shamt = S'($urandom);
        if (push) begin
            model_apply(m, int'(n), b);
            exp_q.push_back('{md, ms});
        end
    endtask

    task automatic wait_idle(output int cyc);
        bit ended = 0;
        cyc = 0;
        samples.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) begin
                ended = 1;
                break;
            end
            samples.push_back(bus.dout);
            cyc++;
        end
        if (!ended) check("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int           cyc;
        int           dc;
        logic [2:0]   m;
        logic [S-1:0] n;
        logic         b;
        logic [W-1:0] exp_seq[3];

        bus.Load   = 1'b0;
        bus.din    = '0;
        bus.start  = 1'b0;
        bus.mode   = '0;
        bus.shamt  = '0;
        bus.ser_in = 1'b0;

        #12;
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_ser_out", 32'(bus.ser_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        // LSL with intermediate values
        do_load(8'hB4);
        issue_start(3'd0, 4'd3, 1'b1, 1);
        wait_idle(cyc);
        check("lsl_busy_cycles", 32'(cyc), 32'd4);
        exp_seq = '{8'h69, 8'hD3, 8'hA7};
        if (samples.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check("lsl_step", 32'(samples[i+1]), 32'(exp_seq[i]));
        end else begin
            check("lsl_samples", 32'(samples.size()), 32'd4);
        end
        check("lsl_final", 32'(bus.dout), 32'hA7);

        // ASR then long LSR
        do_load(8'h90);
        issue_start(3'd2, 4'd2, 1'b0, 1);
        wait_idle(cyc);
        check("asr_dout", 32'(bus.dout), 32'hE4);
        issue_start(3'd1, 4'd9, 1'b0, 1);
        wait_idle(cyc);
        check("lsr9_dout", 32'(bus.dout), 32'h00);

        // Rotate wrap
        do_load(8'h81);
        issue_start(3'd4, 4'd9, 1'b0, 1);
        wait_idle(cyc);
        check("ror9_busy_cycles", 32'(cyc), 32'd10);
        check("ror9_dout", 32'(bus.dout), 32'hC0);

        // Zero amount
        do_load(8'h5C);
        issue_start(3'd0, 4'd0, 1'b1, 1);
        wait_idle(cyc);
        check("shamt0_busy_cycles", 32'(cyc), 32'd1);
        check("shamt0_dout", 32'(bus.dout), 32'h5C);

        // Start while busy is ignored
        dc = done_cnt;
        issue_start(3'd3, 4'd5, 1'b0, 1);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mode  = 3'd0;
        bus.shamt = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle(cyc);
        @(negedge clk);
        check("busy_start_done_count", 32'(done_cnt - dc), 32'd1);

        // Load aborts a rotate after one step
        dc = done_cnt;
        do_load(8'h3C);
        issue_start(3'd3, 4'd6, 1'b0, 0);
        model_apply(3'd3, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.Load = 1'b1;
        bus.din  = 8'h5A;
        @(posedge clk);
        #1;
        bus.Load = 1'b0;
        md = 8'h5A;
        check("abort_dout", 32'(bus.dout), 32'h5A);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_ser_out", 32'(bus.ser_out), 32'(ms));
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        // Start together with Load
        bus.Load  = 1'b1;
        bus.start = 1'b1;
        bus.din   = 8'hC3;
        bus.mode  = 3'd0;
        bus.shamt = 4'd3;
        @(posedge clk);
        #1;
        bus.Load  = 1'b0;
        bus.start = 1'b0;
        md = 8'hC3;
        check("ldstart_dout", 32'(bus.dout), 32'hC3);
        check("ldstart_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("ldstart_busy_late", 32'(bus.busy), 32'h0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) do_load(W'($urandom));
            m = 3'($urandom);
            n = S'($urandom);
            b = 1'($urandom);
            issue_start(m, n, b, 1);
            wait_idle(cyc);
            check("rand_busy_cycles", 32'(cyc), 32'(int'(n) + 1));
        end

        // Asynchronous reset mid-shift
        dc = done_cnt;
        do_load(8'hF0);
        issue_start(3'd0, 4'd8, 1'b1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        md = '0;
        ms = 1'b0;
        check("arst_dout", 32'(bus.dout), 32'h0);
        check("arst_ser_out", 32'(bus.ser_out), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - dc), 32'd0);
        check("arst_busy_after", 32'(bus.busy), 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
